prga: RTL and testbench



---
 rtl/prga.sv | 249 ++++++++++++++++++++++++
 tb/tb_prga.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prga.sv
// rtl/prga.sv - RC4 pseudo-random generation stage (optional keystream taps: PRGA_KEYSTREAM_OUT_EN)
//
// Decrypts a length-prefixed message held in CT memory into PT memory, using
// the S permutation left in S memory by the key-scheduling stage.
// All memory-facing outputs are registered: the FSM state names the cycle in
// which the next memory command is computed, and that command appears on the
// ports at the following edge. Each synchronous read therefore spans a RD_*
// state (address computed) plus a WAIT_* state (RAM samples the address), and
// the data is consumed by whichever state follows.
//
// Define PRGA_KEYSTREAM_OUT_EN to add the ks_valid/ks_byte debug outputs.
module prga #(
  parameter logic [7:0] LEN_ADDR = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
`ifdef PRGA_KEYSTREAM_OUT_EN
  ,
  output logic       ks_valid,
  output logic [7:0] ks_byte
`endif
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_RD_LEN   = 4'd1;
  localparam logic [3:0] ST_WAIT_LEN = 4'd2;
  localparam logic [3:0] ST_WR_LEN   = 4'd3;
  localparam logic [3:0] ST_RD_SI    = 4'd4;
  localparam logic [3:0] ST_WAIT_SI  = 4'd5;
  localparam logic [3:0] ST_RD_SJ    = 4'd6;
  localparam logic [3:0] ST_WAIT_SJ  = 4'd7;
  localparam logic [3:0] ST_WR_I     = 4'd8;
  localparam logic [3:0] ST_WR_J     = 4'd9;
  localparam logic [3:0] ST_RD_PAD   = 4'd10;
  localparam logic [3:0] ST_WAIT_PAD = 4'd11;
  localparam logic [3:0] ST_WR_PT    = 4'd12;

  logic [3:0] state_q, state_d;
  logic       rdy_q, rdy_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] k_q, k_d;
  logic [7:0] len_q, len_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  // WAIT_PAD spans two cycles: the CT read is launched in its first cycle and
  // needs one more cycle before the RAM has sampled it.
  logic       pad_ph_q, pad_ph_d;

  logic [7:0] s_addr_q, s_addr_d;
  logic [7:0] s_wrdata_q, s_wrdata_d;
  logic       s_wren_q, s_wren_d;
  logic [7:0] ct_addr_q, ct_addr_d;
  logic [7:0] pt_addr_q, pt_addr_d;
  logic [7:0] pt_wrdata_q, pt_wrdata_d;
  logic       pt_wren_q, pt_wren_d;

`ifdef PRGA_KEYSTREAM_OUT_EN
  logic       ks_valid_q, ks_valid_d;
  logic [7:0] ks_byte_q, ks_byte_d;
`endif

  // Next-state and next-command computation for the whole RC4 byte loop
  always_comb begin
    state_d     = state_q;
    rdy_d       = rdy_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    len_d       = len_q;
    si_d        = si_q;
    sj_d        = sj_q;
    pad_ph_d    = 1'b0;
    s_addr_d    = s_addr_q;
    s_wrdata_d  = s_wrdata_q;
    s_wren_d    = 1'b0;
    ct_addr_d   = ct_addr_q;
    pt_addr_d   = pt_addr_q;
    pt_wrdata_d = pt_wrdata_q;
    pt_wren_d   = 1'b0;
`ifdef PRGA_KEYSTREAM_OUT_EN
    ks_valid_d  = 1'b0;
    ks_byte_d   = ks_byte_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // rdy is raised one cycle after the last write was presented, so a
        // finished run lands here with rdy low and only then becomes ready.
        if (!rdy_q) begin
          rdy_d = 1'b1;
        end else if (en) begin
          rdy_d   = 1'b0;
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = 8'd0;
          state_d = ST_RD_LEN;
        end
      end
      ST_RD_LEN: begin
        ct_addr_d = LEN_ADDR;
        state_d   = ST_WAIT_LEN;
      end
      ST_WAIT_LEN: begin
        state_d = ST_WR_LEN;
      end
      ST_WR_LEN: begin
        len_d       = ct_rddata;
        pt_addr_d   = LEN_ADDR;
        pt_wrdata_d = ct_rddata;
        pt_wren_d   = 1'b1;
        state_d     = (ct_rddata == 8'd0) ? ST_IDLE : ST_RD_SI;
      end
      ST_RD_SI: begin
        i_d      = i_q + 8'd1;
        k_d      = k_q + 8'd1;
        s_addr_d = i_q + 8'd1;
        state_d  = ST_WAIT_SI;
      end
      ST_WAIT_SI: begin
        state_d = ST_RD_SJ;
      end
      ST_RD_SJ: begin
        si_d     = s_rddata;
        j_d      = j_q + s_rddata;
        s_addr_d = j_q + s_rddata;
        state_d  = ST_WAIT_SJ;
      end
      ST_WAIT_SJ: begin
        state_d = ST_WR_I;
      end
      ST_WR_I: begin
        sj_d       = s_rddata;
        s_addr_d   = i_q;
        s_wrdata_d = s_rddata;
        s_wren_d   = 1'b1;
        state_d    = ST_WR_J;
      end
      ST_WR_J: begin
        // Issued after S[i]=sj, so when i==j this write of si wins.
        s_addr_d   = j_q;
        s_wrdata_d = si_q;
        s_wren_d   = 1'b1;
        state_d    = ST_RD_PAD;
      end
      ST_RD_PAD: begin
        s_addr_d = si_q + sj_q;
        state_d  = ST_WAIT_PAD;
      end
      ST_WAIT_PAD: begin
        if (!pad_ph_q) begin
          ct_addr_d = LEN_ADDR + k_q;
          pad_ph_d  = 1'b1;
        end else begin
          state_d = ST_WR_PT;
        end
      end
      ST_WR_PT: begin
        pt_addr_d   = LEN_ADDR + k_q;
        pt_wrdata_d = s_rddata ^ ct_rddata;
        pt_wren_d   = 1'b1;
`ifdef PRGA_KEYSTREAM_OUT_EN
        ks_valid_d  = 1'b1;
        ks_byte_d   = s_rddata;
`endif
        state_d     = (k_q == len_q) ? ST_IDLE : ST_RD_SI;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered memory-command outputs; reset aborts any run at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b1;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      k_q         <= 8'd0;
      len_q       <= 8'd0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
      pad_ph_q    <= 1'b0;
      s_addr_q    <= 8'd0;
      s_wrdata_q  <= 8'd0;
      s_wren_q    <= 1'b0;
      ct_addr_q   <= 8'd0;
      pt_addr_q   <= 8'd0;
      pt_wrdata_q <= 8'd0;
      pt_wren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      len_q       <= len_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      pad_ph_q    <= pad_ph_d;
      s_addr_q    <= s_addr_d;
      s_wrdata_q  <= s_wrdata_d;
      s_wren_q    <= s_wren_d;
      ct_addr_q   <= ct_addr_d;
      pt_addr_q   <= pt_addr_d;
      pt_wrdata_q <= pt_wrdata_d;
      pt_wren_q   <= pt_wren_d;
    end
  end

`ifdef PRGA_KEYSTREAM_OUT_EN
  // Keystream debug taps, aligned with the PT write they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_valid_q <= 1'b0;
      ks_byte_q  <= 8'd0;
    end else begin
      ks_valid_q <= ks_valid_d;
      ks_byte_q  <= ks_byte_d;
    end
  end

  assign ks_valid = ks_valid_q;
  assign ks_byte  = ks_byte_q;
`endif

  assign rdy       = rdy_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign ct_addr   = ct_addr_q;
  assign pt_addr   = pt_addr_q;
  assign pt_wrdata = pt_wrdata_q;
  assign pt_wren   = pt_wren_q;

endmodule

// File: tb/tb_prga.sv
// tb/tb_prga.sv - randomized scoreboard bench for prga against an RC4 reference model
`timescale 1ns/1ps
module tb_prga;
  localparam logic [7:0] LEN = 8'd200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;
`ifdef PRGA_KEYSTREAM_OUT_EN
  logic       ks_valid;
  logic [7:0] ks_byte;
`endif

  always #5 clk = ~clk;

  prga #(.LEN_ADDR(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
`ifdef PRGA_KEYSTREAM_OUT_EN
    , .ks_valid(ks_valid), .ks_byte(ks_byte)
`endif
  );

  // Synchronous RAMs: address sampled at an edge, data visible after it
  logic [7:0] s_mem [256];
  logic [7:0] s_init [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] s_rd_q, ct_rd_q;
  logic       load_req;

  always @(posedge clk) begin
    if (load_req) begin
      for (int n = 0; n < 256; n++) s_mem[n] <= s_init[n];
    end else if (s_wren) begin
      s_mem[s_addr] <= s_wrdata;
    end
    s_rd_q  <= s_mem[s_addr];
    ct_rd_q <= ct_mem[ct_addr];
    if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
  end
  assign s_rddata  = s_rd_q;
  assign ct_rddata = ct_rd_q;

  int          n_vec = 0;
  int          n_fail = 0;
  int          s_wren_cnt = 0;
  logic [15:0] exp_q [$];
  logic [7:0]  ms [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented PT write is popped against the scoreboard
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (s_wren) s_wren_cnt++;
      if (pt_wren) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL pt_unexpected: got addr %0h data %0h with empty scoreboard", pt_addr, pt_wrdata);
        end else begin
          e = exp_q.pop_front();
          chk("pt_write", {16'd0, pt_addr, pt_wrdata}, {16'd0, e});
        end
      end
    end
  end

  // Reference: plain RC4 PRGA over the model copy of S
  task automatic model_run(input int L);
    int i, j, a;
    logic [7:0] si, sj;
    i = 0;
    j = 0;
    exp_q.push_back({LEN, 8'(L)});
    for (int k = 1; k <= L; k++) begin
      i = (i + 1) % 256;
      si = ms[i];
      j = (j + int'(si)) % 256;
      sj = ms[j];
      ms[i] = sj;
      ms[j] = si;
      a = (int'(si) + int'(sj)) % 256;
      exp_q.push_back({8'(int'(LEN) + k), ms[a] ^ ct_mem[8'(int'(LEN) + k)]});
    end
  endtask

  task automatic load_s();
    for (int n = 0; n < 256; n++) ms[n] = s_init[n];
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic init_identity();
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
  endtask

  task automatic init_perm();
    logic [7:0] t;
    int r;
    init_identity();
    for (int n = 255; n > 0; n--) begin
      r = $urandom_range(0, n);
      t = s_init[n];
      s_init[n] = s_init[r];
      s_init[r] = t;
    end
  endtask

  task automatic init_ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
    logic [7:0] key [3];
    logic [7:0] t;
    int j;
    key[0] = k0; key[1] = k1; key[2] = k2;
    init_identity();
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + int'(s_init[n]) + int'(key[n % 3])) % 256;
      t = s_init[n];
      s_init[n] = s_init[j];
      s_init[j] = t;
    end
  endtask

  task automatic load_ct_rand(input int L);
    ct_mem[LEN] = 8'(L);
    for (int k = 1; k <= L; k++) ct_mem[8'(int'(LEN) + k)] = 8'($urandom);
  endtask

  // One request; returns cycles from acceptance to rdy (or to abort point)
  task automatic run_msg(input bit toggle, input int abort_at, output int cyc);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    cyc = 0;
    #1;
    en = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
    while (cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == abort_at) break;
      if (rdy) break;
      if (toggle) en = 1'($urandom_range(0, 1));
    end
    en = 1'b0;
  endtask

  task automatic check_s_final(input string name);
    int bad;
    bad = 0;
    for (int n = 0; n < 256; n++) if (s_mem[n] !== ms[n]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic model_and_run(input int L, input bit toggle);
    int cyc;
    model_run(L);
    run_msg(toggle, 0, cyc);
    chk("latency", cyc, 4 + 10 * L);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    check_s_final("s_final");
  endtask

  initial begin
    int cyc, wr0;
    rst_n = 1'b0;
    en = 1'b0;
    load_req = 1'b0;
    for (int n = 0; n < 256; n++) begin
      ct_mem[n] = 8'd0;
      s_init[n] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", rdy, 1);
    chk("reset_wren", {s_wren, pt_wren}, 0);
    chk("reset_addr", {s_addr, ct_addr, pt_addr}, 0);
    chk("reset_wrdata", {s_wrdata, pt_wrdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Identity S, zero ciphertext: pad bytes 2,5,7; first byte has i==j
    init_identity();
    load_s();
    ct_mem[LEN] = 8'd3;
    for (int k = 1; k <= 3; k++) ct_mem[8'(int'(LEN) + k)] = 8'h00;
    exp_q.push_back({LEN, 8'd3});
    exp_q.push_back({8'(LEN + 8'd1), 8'h02});
    exp_q.push_back({8'(LEN + 8'd2), 8'h05});
    exp_q.push_back({8'(LEN + 8'd3), 8'h07});
    run_msg(1'b0, 0, cyc);
    chk("latency_l3", cyc, 34);
    @(negedge clk);
    chk("s1", s_mem[1], 8'd1);
    chk("s2", s_mem[2], 8'd3);
    chk("s3", s_mem[3], 8'd5);
    chk("s5", s_mem[5], 8'd2);

    // Identity S, "ABC"
    init_identity();
    load_s();
    ct_mem[8'(LEN + 8'd1)] = 8'h41;
    ct_mem[8'(LEN + 8'd2)] = 8'h42;
    ct_mem[8'(LEN + 8'd3)] = 8'h43;
    exp_q.push_back({LEN, 8'd3});
    exp_q.push_back({8'(LEN + 8'd1), 8'h43});
    exp_q.push_back({8'(LEN + 8'd2), 8'h47});
    exp_q.push_back({8'(LEN + 8'd3), 8'h44});
    run_msg(1'b0, 0, cyc);
    chk("latency_abc", cyc, 34);

    // Empty message: only the length is copied, S untouched
    init_perm();
    load_s();
    ct_mem[LEN] = 8'd0;
    wr0 = s_wren_cnt;
    model_and_run(0, 1'b0);
    chk("l0_no_s_wren", s_wren_cnt - wr0, 0);

    // en toggled throughout a 3-byte run must not restart it
    init_perm();
    load_s();
    load_ct_rand(3);
    model_and_run(3, 1'b1);

    // Reset during WR_J of byte 2, then a clean run from reloaded S
    init_identity();
    load_s();
    load_ct_rand(3);
    model_run(3);
    run_msg(1'b0, 18, cyc);
    rst_n = 1'b0;
    #1;
    chk("abort_rdy", rdy, 1);
    chk("abort_wren", {s_wren, pt_wren}, 0);
    chk("abort_written_byte1", exp_q.size(), 2);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    init_identity();
    load_s();
    model_and_run(3, 1'b0);

    // S from key scheduling with key 00 00 18, full-length message wrapping addresses
    init_ksa(8'h00, 8'h00, 8'h18);
    load_s();
    load_ct_rand(255);
    model_and_run(255, 1'b0);

    // Chained random messages continuing from the S each run leaves behind
    init_perm();
    load_s();
    for (int r = 0; r < 6; r++) begin
      int L;
      L = (r == 0) ? 1 : int'($urandom_range(1, 40));
      load_ct_rand(L);
      model_and_run(L, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
